// File: rtl/toysram_scan_ctrl.sv
// Scan-chain controller: pad-driven shift chains with parallel capture and shadow update registers.
// Latency: a pad scan_clk rise shifts on the 3rd core edge; scan_par (TOYSRAM_SCAN_PARITY_EN) lags one cycle.
// Backpressure: none; cap takes priority over a coincident shift strobe, and that strobe is dropped.
module toysram_scan_ctrl #(
    parameter int WIDTH  = 128,
    parameter int CHAINS = 2,
    localparam int SW    = (CHAINS > 1) ? $clog2(CHAINS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      te,
    input  logic                      scan_clk,
    input  logic                      scan_di,
    input  logic [SW-1:0]             scan_sel,
    input  logic                      cap,
    input  logic [CHAINS*WIDTH-1:0]   par_in,
    output logic                      scan_do,
    output logic [CHAINS*WIDTH-1:0]   par_out,
    output logic                      upd_done,
    output logic                      cnt_ok,
    output logic                      scan_par
);

    localparam int MW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, TEST, UPDATE} state_t;

    state_t             state;
    state_t             state_next;
    logic               te_s1, te_s2, te_d;
    logic               sck_s1, sck_s2, sck_d;
    logic               di_s1, di_s2;
    logic               strobe, te_rise, te_fall;
    logic               shift_en, test_entry, shadow_load;
    logic               sel_ok;
    logic [WIDTH-1:0]   chain [CHAINS];
    logic [WIDTH-1:0]   sel_chain;
    logic [WIDTH-1:0]   cap_slice;
    logic [15:0]        cnt;
    logic [MW-1:0]      mod_cnt;

    // Pad synchronizers; scan_di goes through the same depth so it lines up with the strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            te_s1  <= 1'b0;
            te_s2  <= 1'b0;
            te_d   <= 1'b0;
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_d  <= 1'b0;
            di_s1  <= 1'b0;
            di_s2  <= 1'b0;
        end else begin
            te_s1  <= te;
            te_s2  <= te_s1;
            te_d   <= te_s2;
            sck_s1 <= scan_clk;
            sck_s2 <= sck_s1;
            sck_d  <= sck_s2;
            di_s1  <= scan_di;
            di_s2  <= di_s1;
        end
    end

    assign strobe   = sck_s2 & ~sck_d;
    assign te_rise  = te_s2 & ~te_d;
    assign te_fall  = ~te_s2 & te_d;
    assign shift_en = strobe & te_s2 & ~cap & sel_ok;

    // Select the addressed chain and capture slice; out-of-range selects read as zero
    always_comb begin
        sel_ok    = 1'b0;
        sel_chain = '0;
        cap_slice = '0;
        for (int c = 0; c < CHAINS; c++) begin
            if (SW'(c) == scan_sel) begin
                sel_ok    = 1'b1;
                sel_chain = chain[c];
                cap_slice = par_in[c*WIDTH +: WIDTH];
            end
        end
    end

    assign scan_do = sel_chain[WIDTH-1];

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (te_rise) state_next = TEST;
            TEST:    if (te_fall) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: shadows load on the edge entering UPDATE so par_out is valid while upd_done is high
    always_comb begin
        upd_done    = (state == UPDATE);
        test_entry  = (state == IDLE) && te_rise;
        shadow_load = (state == TEST) && te_fall;
    end

    // Chains: capture beats shift; only the selected chain moves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHAINS; c++) chain[c] <= '0;
        end else begin
            for (int c = 0; c < CHAINS; c++) begin
                if (SW'(c) == scan_sel) begin
                    if (cap)           chain[c] <= cap_slice;
                    else if (shift_en) chain[c] <= {chain[c][WIDTH-2:0], di_s2};
                end
            end
        end
    end

    // Saturating shift count plus a running residue mod WIDTH, both frozen once saturated
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            mod_cnt <= '0;
        end else if (test_entry) begin
            cnt     <= shift_en ? 16'd1 : 16'd0;
            mod_cnt <= shift_en ? MW'(1) : '0;
        end else if (shift_en && (cnt != 16'hFFFF)) begin
            cnt     <= cnt + 16'd1;
            mod_cnt <= (mod_cnt == MW'(WIDTH-1)) ? '0 : mod_cnt + 1'b1;
        end
    end

    // Shadow registers and the word-count verdict, both refreshed only on UPDATE entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_out <= '0;
            cnt_ok  <= 1'b0;
        end else if (shadow_load) begin
            for (int c = 0; c < CHAINS; c++) par_out[c*WIDTH +: WIDTH] <= chain[c];
            cnt_ok <= (cnt != 16'd0) && (mod_cnt == '0);
        end
    end

`ifdef TOYSRAM_SCAN_PARITY_EN
    // Registered parity of the selected chain
    always_ff @(posedge clk) begin
        if (!rst_n) scan_par <= 1'b0;
        else        scan_par <= ^sel_chain;
    end
`else
    assign scan_par = 1'b0;
`endif

endmodule

// File: tb/tb_toysram_scan_ctrl.sv
// Bench for toysram_scan_ctrl: scoreboarded shadow updates plus per-strobe scan_do/scan_par checks.
// Reference model tracks chain words, shift counts and test sessions directly.
// Optional parity checked when TOYSRAM_SCAN_PARITY_EN is defined.
module tb_toysram_scan_ctrl;

    localparam int W = 128;
    localparam int C = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             te;
    logic             scan_clk;
    logic             scan_di;
    logic [0:0]       scan_sel;
    logic             cap;
    logic [C*W-1:0]   par_in;
    logic             scan_do;
    logic [C*W-1:0]   par_out;
    logic             upd_done;
    logic             cnt_ok;
    logic             scan_par;

    toysram_scan_ctrl #(.WIDTH(W), .CHAINS(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .te       (te),
        .scan_clk (scan_clk),
        .scan_di  (scan_di),
        .scan_sel (scan_sel),
        .cap      (cap),
        .par_in   (par_in),
        .scan_do  (scan_do),
        .par_out  (par_out),
        .upd_done (upd_done),
        .cnt_ok   (cnt_ok),
        .scan_par (scan_par)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [C*W-1:0] par;
        logic           ok;
    } exp_t;

    exp_t           expq[$];
    int             checks   = 0;
    int             failures = 0;
    logic [W-1:0]   mch [C];
    int             mcount;
    bit             mtest;

    task automatic check(input string name, input logic [C*W-1:0] act, input logic [C*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [C*W-1:0] model_par();
        logic [C*W-1:0] p;
        for (int c = 0; c < C; c++) p[c*W +: W] = mch[c];
        return p;
    endfunction

    function automatic logic model_parity(input int s);
`ifdef TOYSRAM_SCAN_PARITY_EN
        return ^mch[s];
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int c = 0; c < C; c++) mch[c] = '0;
        mcount = 0;
        mtest  = 1'b0;
    endtask

    // Monitor: every upd_done cycle must match the oldest expected shadow update
    always @(negedge clk) begin
        if (upd_done !== 1'b0) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_upd_done actual=%b expected=0", upd_done);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("par_out", par_out, e.par);
                check("cnt_ok", cnt_ok, e.ok);
            end
        end
    end

    task automatic set_te(input logic v);
        te = v;
        if (v) begin
            mtest  = 1'b1;
            mcount = 0;
        end else if (mtest) begin
            exp_t e;
            e.par = model_par();
            e.ok  = (mcount != 0) && (mcount % W == 0);
            expq.push_back(e);
            mtest = 1'b0;
        end
        wait_cycles(8);
    endtask

    // One pad scan_clk pulse; optional cap lands on the very cycle the strobe reaches the chain
    task automatic pulse(input logic di, input bit with_cap, input logic [W-1:0] cval);
        int s;
        s = int'(scan_sel);
        check("scan_do", scan_do, mch[s][W-1]);
        check("scan_par", scan_par, model_parity(s));
        scan_di  = di;
        scan_clk = 1'b1;
        wait_cycles(2);
        if (with_cap) begin
            cap = 1'b1;
            par_in[s*W +: W] = cval;
        end
        wait_cycles(1);
        cap = 1'b0;
        wait_cycles(2);
        scan_clk = 1'b0;
        wait_cycles(4);
        if (with_cap) begin
            mch[s] = cval;
        end else if (te) begin
            mch[s] = {mch[s][W-2:0], di};
            mcount++;
        end
    endtask

    initial begin
        logic [W-1:0] word;
        logic [W-1:0] aaaa;
        int           n;

        rst_n = 1'b0; te = 1'b0; scan_clk = 1'b0; scan_di = 1'b0;
        cap = 1'b0; scan_sel = 1'b0; par_in = '0;
        model_reset();
        wait_cycles(3);
        check("rst_par_out", par_out, '0);
        check("rst_scan_do", scan_do, 1'b0);
        check("rst_upd_done", upd_done, 1'b0);
        check("rst_cnt_ok", cnt_ok, 1'b0);
        check("rst_scan_par", scan_par, 1'b0);
        rst_n = 1'b1;
        wait_cycles(2);

        // Known word into chain 0, MSB first
        word = 128'h0123456789ABCDEFFEDCBA9876543210;
        set_te(1'b1);
        for (int i = W-1; i >= 0; i--) pulse(word[i], 1'b0, '0);
        set_te(1'b0);

        // Shift it back out while loading random data
        set_te(1'b1);
        for (int i = 0; i < W; i++) pulse(1'($urandom_range(0, 1)), 1'b0, '0);
        set_te(1'b0);

        // Strobes with te low are ignored
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, '0);

        // Capture colliding with a strobe on chain 1, then a partial word
        scan_sel = 1'b1;
        wait_cycles(2);
        set_te(1'b1);
        aaaa = {(W/2){2'b10}};
        pulse(1'b1, 1'b1, aaaa);
        check("cap_msb", scan_do, 1'b1);
        for (int i = 0; i < 100; i++) pulse(1'($urandom_range(0, 1)), 1'b0, '0);
        set_te(1'b0);

        // Random sessions with occasional chain switching
        for (int k = 0; k < 3; k++) begin
            n = (k == 0) ? W : (k == 1) ? 2*W : int'($urandom_range(1, 200));
            set_te(1'b1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    scan_sel = ~scan_sel;
                    wait_cycles(2);
                end
                pulse(1'($urandom_range(0, 1)), 1'b0, '0);
            end
            set_te(1'b0);
        end

        // Reset mid-shift discards everything, no update afterwards
        scan_sel = 1'b0;
        wait_cycles(2);
        set_te(1'b1);
        for (int i = 0; i < 64; i++) pulse(1'($urandom_range(0, 1)), 1'b0, '0);
        rst_n = 1'b0;
        wait_cycles(2);
        model_reset();
        check("midrst_par_out", par_out, '0);
        check("midrst_scan_do", scan_do, 1'b0);
        check("midrst_cnt_ok", cnt_ok, 1'b0);
        check("midrst_upd_done", upd_done, 1'b0);
        te = 1'b0;
        wait_cycles(4);
        rst_n = 1'b1;
        wait_cycles(10);

        // te already high at reset release counts as a rise
        rst_n = 1'b0;
        te    = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        mtest  = 1'b1;
        mcount = 0;
        wait_cycles(6);
        for (int i = 0; i < W; i++) pulse(1'($urandom_range(0, 1)), 1'b0, '0);
        set_te(1'b0);

        // Parity: chain0 = ...0001, then switch to an all-zero chain1
        rst_n = 1'b0;
        wait_cycles(2);
        model_reset();
        rst_n = 1'b1;
        scan_sel = 1'b0;
        wait_cycles(2);
        set_te(1'b1);
        pulse(1'b1, 1'b0, '0);
        check("par_chain0", scan_par, model_parity(0));
        scan_sel = 1'b1;
        wait_cycles(1);
        check("par_chain1", scan_par, model_parity(1));
        set_te(1'b0);

        for (int i = 0; i < 20 && expq.size() != 0; i++) wait_cycles(1);
        check("pending_updates", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
